// File: rtl/deconv_pkg.sv
// rtl/deconv_pkg.sv - shared types, config field layout and helpers for the deconv column feeder
package deconv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WFETCH   = 3'd1,
    ST_FFETCH   = 3'd2,
    ST_WAIT_COL = 3'd3,
    ST_REPLAY   = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  localparam int FCOLS_LSB   = 0;
  localparam int NCHNL_LSB   = 16;
  localparam int KCOLS_LSB   = 0;
  localparam int CFG_FIELD_W = 16;

  // A zero or oversized weight-column count means "use the whole kernel width".
  function automatic logic [CFG_FIELD_W-1:0] clamp_kcols(
    input logic [CFG_FIELD_W-1:0] raw,
    input logic [CFG_FIELD_W-1:0] max_cols
  );
    if ((raw == '0) || (raw > max_cols)) begin
      return max_cols;
    end
    return raw;
  endfunction

endpackage

// File: rtl/deconv_wbuf.sv
// rtl/deconv_wbuf.sv - weight column register file, one write port, one combinational read port
module deconv_wbuf #(
  parameter int DEPTH = 5,
  parameter int WIDTH = 40,
  parameter int AW    = 3
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is never reset; every entry read in a channel is written first.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/deconv_col_feeder.sv
// rtl/deconv_col_feeder.sv - fetches and replays weight columns and feeds feature columns to the column core
module deconv_col_feeder
  import deconv_pkg::*;
#(
  parameter int SIZE_OF_WEIGHT  = 5,
  parameter int SIZE_OF_FEATURE = 2,
  parameter int PIX_WIDTH       = 8,
  parameter int REG_WIDTH       = 32,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic                                 i_start,
  input  logic [REG_WIDTH-1:0]                 i_param_cfg_feature,
  input  logic [REG_WIDTH-1:0]                 i_param_cfg_weight,
  input  logic [PIX_WIDTH*SIZE_OF_WEIGHT-1:0]  s_weight_tdata,
  input  logic                                 s_weight_tvalid,
  output logic                                 s_weight_tready,
  input  logic [PIX_WIDTH*SIZE_OF_FEATURE-1:0] s_feature_tdata,
  input  logic                                 s_feature_tvalid,
  output logic                                 s_feature_tready,
  input  logic                                 i_en_prcs_new_wcoln,
  output logic [PIX_WIDTH*SIZE_OF_WEIGHT-1:0]  o_weight_col,
  output logic [PIX_WIDTH*SIZE_OF_FEATURE-1:0] o_feature_map_col,
  output logic                                 o_enable_loadw,
  output logic                                 o_enable_loadip,
  output logic                                 o_busy,
  output logic                                 o_done
);

  localparam int WCOL_W = PIX_WIDTH * SIZE_OF_WEIGHT;
  localparam int AW     = (SIZE_OF_WEIGHT > 1) ? $clog2(SIZE_OF_WEIGHT) : 1;
  localparam logic [CFG_FIELD_W-1:0] MAX_KCOLS = CFG_FIELD_W'(SIZE_OF_WEIGHT);

  state_t state, state_nxt;

  logic [AW-1:0]          k;
  logic [AW-1:0]          rp;
  logic [AW-1:0]          kcols_last;
  logic [CNT_WIDTH-1:0]   f;
  logic [CNT_WIDTH-1:0]   c;
  logic [CNT_WIDTH-1:0]   fcols;
  logic [CNT_WIDTH-1:0]   nchnl;
  logic [CFG_FIELD_W-1:0] cfg_fcols;
  logic [CFG_FIELD_W-1:0] cfg_nchnl;
  logic [CFG_FIELD_W-1:0] cfg_kcols;
  logic [WCOL_W-1:0]      rd_col;
  logic                   w_xfer;
  logic                   f_xfer;
  logic                   k_last;
  logic                   rp_last;
  logic                   f_last;
  logic                   c_last;
  logic                   unused_cfg_weight;

  assign cfg_fcols = i_param_cfg_feature[FCOLS_LSB +: CFG_FIELD_W];
  assign cfg_nchnl = i_param_cfg_feature[NCHNL_LSB +: CFG_FIELD_W];
  assign cfg_kcols = i_param_cfg_weight[KCOLS_LSB +: CFG_FIELD_W];
  assign unused_cfg_weight = ^i_param_cfg_weight[REG_WIDTH-1:KCOLS_LSB+CFG_FIELD_W];

  assign w_xfer  = s_weight_tvalid && (state == ST_WFETCH);
  assign f_xfer  = s_feature_tvalid && (state == ST_FFETCH);
  assign k_last  = (k == kcols_last);
  assign rp_last = (rp == kcols_last);
  assign f_last  = (f == fcols - CNT_WIDTH'(1));
  assign c_last  = (c == nchnl - CNT_WIDTH'(1));

  deconv_wbuf #(
    .DEPTH (SIZE_OF_WEIGHT),
    .WIDTH (WCOL_W),
    .AW    (AW)
  ) u_wbuf (
    .i_clk   (i_clk),
    .i_we    (w_xfer),
    .i_waddr (k),
    .i_wdata (s_weight_tdata),
    .i_raddr (rp),
    .o_rdata (rd_col)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: fetch weights, feed a feature column, wait for the core, replay or advance.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          state_nxt = ((cfg_fcols == '0) || (cfg_nchnl == '0)) ? ST_DONE : ST_WFETCH;
        end
      end
      ST_WFETCH: begin
        if (w_xfer && k_last) begin
          state_nxt = ST_FFETCH;
        end
      end
      ST_FFETCH: begin
        if (f_xfer) begin
          state_nxt = ST_WAIT_COL;
        end
      end
      ST_WAIT_COL: begin
        if (i_en_prcs_new_wcoln) begin
          if (!f_last) begin
            state_nxt = ST_REPLAY;
          end else if (!c_last) begin
            state_nxt = ST_WFETCH;
          end else begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_REPLAY: begin
        if (rp_last) begin
          state_nxt = ST_FFETCH;
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs: stream readies, busy and done.
  always_comb begin
    s_weight_tready  = (state == ST_WFETCH);
    s_feature_tready = (state == ST_FFETCH);
    o_busy           = (state != ST_IDLE) && (state != ST_DONE);
    o_done           = (state == ST_DONE);
  end

  // Datapath: config latch, column/channel counters, registered column buses and load strobes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      k                 <= '0;
      rp                <= '0;
      kcols_last        <= '0;
      f                 <= '0;
      c                 <= '0;
      fcols             <= '0;
      nchnl             <= '0;
      o_weight_col      <= '0;
      o_feature_map_col <= '0;
      o_enable_loadw    <= 1'b0;
      o_enable_loadip   <= 1'b0;
    end else begin
      o_enable_loadw  <= 1'b0;
      o_enable_loadip <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            fcols      <= CNT_WIDTH'(cfg_fcols);
            nchnl      <= CNT_WIDTH'(cfg_nchnl);
            kcols_last <= AW'(clamp_kcols(cfg_kcols, MAX_KCOLS) - CFG_FIELD_W'(1));
            k          <= '0;
            rp         <= '0;
            f          <= '0;
            c          <= '0;
          end
        end
        ST_WFETCH: begin
          if (w_xfer) begin
            o_weight_col   <= s_weight_tdata;
            o_enable_loadw <= 1'b1;
            k              <= k_last ? '0 : k + AW'(1);
          end
        end
        ST_FFETCH: begin
          if (f_xfer) begin
            o_feature_map_col <= s_feature_tdata;
            o_enable_loadip   <= 1'b1;
          end
        end
        ST_WAIT_COL: begin
          if (i_en_prcs_new_wcoln) begin
            if (!f_last) begin
              f  <= f + CNT_WIDTH'(1);
              rp <= '0;
            end else if (!c_last) begin
              c <= c + CNT_WIDTH'(1);
              f <= '0;
              k <= '0;
            end
          end
        end
        ST_REPLAY: begin
          o_weight_col   <= rd_col;
          o_enable_loadw <= 1'b1;
          rp             <= rp_last ? '0 : rp + AW'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_deconv_col_feeder.sv
// tb/tb_deconv_col_feeder.sv - directed self-checking bench for deconv_col_feeder
module tb_deconv_col_feeder;

  localparam int SOW = 5;
  localparam int SOF = 2;
  localparam int PW  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_start;
  logic [31:0]       cfg_feature;
  logic [31:0]       cfg_weight;
  logic [PW*SOW-1:0] w_tdata;
  logic              w_tvalid;
  logic              w_tready;
  logic [PW*SOF-1:0] f_tdata;
  logic              f_tvalid;
  logic              f_tready;
  logic              wcoln;
  logic [PW*SOW-1:0] weight_col;
  logic [PW*SOF-1:0] feature_col;
  logic              loadw;
  logic              loadip;
  logic              busy;
  logic              done;

  deconv_col_feeder dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_start             (i_start),
    .i_param_cfg_feature (cfg_feature),
    .i_param_cfg_weight  (cfg_weight),
    .s_weight_tdata      (w_tdata),
    .s_weight_tvalid     (w_tvalid),
    .s_weight_tready     (w_tready),
    .s_feature_tdata     (f_tdata),
    .s_feature_tvalid    (f_tvalid),
    .s_feature_tready    (f_tready),
    .i_en_prcs_new_wcoln (wcoln),
    .o_weight_col        (weight_col),
    .o_feature_map_col   (feature_col),
    .o_enable_loadw      (loadw),
    .o_enable_loadip     (loadip),
    .o_busy              (busy),
    .o_done              (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Monitor: logs strobes, transfers and ready cycles, sampled on the falling edge.
  int               cyc = 0;
  int               nw = 0, nf = 0, nwx = 0, nboth = 0, ndone = 0, nrdy = 0;
  logic [PW*SOW-1:0] wlog [256];
  int               wcyc [256];
  int               wxcyc [256];
  logic [PW*SOF-1:0] flog [256];
  int               fcyc [256];

  always @(negedge clk) begin
    cyc++;
    if (loadw) begin
      if (nw < 256) begin
        wlog[nw] = weight_col;
        wcyc[nw] = cyc;
      end
      nw++;
    end
    if (loadip) begin
      if (nf < 256) begin
        flog[nf] = feature_col;
        fcyc[nf] = cyc;
      end
      nf++;
    end
    if (w_tvalid && w_tready) begin
      if (nwx < 256) wxcyc[nwx] = cyc;
      nwx++;
    end
    if (loadw && loadip) nboth++;
    if (w_tready || f_tready) nrdy++;
    if (done) ndone++;
  end

  int   widx, fidx;
  bit   wtog, phase;
  logic wfire, ffire;
  int   bw, bf, bwx, bd, br, bb;

  function automatic logic [PW*SOW-1:0] wcol(input int i);
    logic [7:0] b;
    b = 8'(1 + (i % 5) + 16 * (i / 5));
    return {5{b}};
  endfunction

  function automatic logic [PW*SOF-1:0] fcol(input int i);
    logic [7:0] b;
    b = 8'(8'hA0 + i);
    return {2{b}};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    w_tdata  = wcol(widx);
    w_tvalid = wtog ? phase : 1'b1;
    f_tdata  = fcol(fidx);
    f_tvalid = 1'b1;
  endtask

  task automatic step();
    @(negedge clk);
    wfire = w_tvalid & w_tready;
    ffire = f_tvalid & f_tready;
    @(posedge clk);
    #1;
    if (wfire) widx++;
    if (ffire) fidx++;
    phase = ~phase;
    drive();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic snap();
    bw = nw; bf = nf; bwx = nwx; bd = ndone; br = nrdy; bb = nboth;
  endtask

  task automatic start_job(input int kc, input int fc, input int nc);
    cfg_weight  = 32'(kc);
    cfg_feature = {16'(nc), 16'(fc)};
    widx = 0; fidx = 0; phase = 1'b0;
    drive();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic pulse_wcoln();
    wcoln = 1'b1;
    step();
    wcoln = 1'b0;
  endtask

  function automatic logic [63:0] all_outs();
    return {7'd0, weight_col, feature_col, loadw, loadip, busy, done, w_tready, f_tready};
  endfunction

  initial begin
    rst_n = 1'b0; i_start = 1'b0; wcoln = 1'b0; wtog = 1'b0;
    cfg_feature = '0; cfg_weight = '0;
    widx = 0; fidx = 0; phase = 1'b0;
    drive();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", all_outs(), 64'd0);
    rst_n = 1'b1;
    steps(2);
    check("idle_outputs", all_outs(), 64'd0);

    // Basic job: KCOLS=5, FCOLS=2, NCHNL=1
    snap();
    start_job(5, 2, 1);
    check("basic_busy", {62'd0, busy, w_tready}, 64'h3);
    steps(8);
    check("basic_fetch_loadw", 64'(nw - bw), 64'd5);
    check("basic_fetch_loadip", 64'(nf - bf), 64'd1);
    check("basic_fetch_consec", 64'(wcyc[bw+4] - wcyc[bw]), 64'd4);
    check("basic_loadip_after", 64'(fcyc[bf] - wcyc[bw+4]), 64'd1);
    check("basic_fcol0", flog[bf], fcol(0));
    for (int i = 0; i < 5; i++) check("basic_fetch_data", wlog[bw+i], wcol(i));
    check("basic_waitcol_rdy", {62'd0, w_tready, f_tready}, 64'd0);
    pulse_wcoln();
    steps(8);
    check("basic_replay_loadw", 64'(nw - bw), 64'd10);
    check("basic_replay_consec", 64'(wcyc[bw+9] - wcyc[bw+5]), 64'd4);
    for (int i = 0; i < 5; i++) check("basic_replay_data", wlog[bw+5+i], wcol(i));
    check("basic_loadip2", 64'(nf - bf), 64'd2);
    check("basic_fcol1", flog[bf+1], fcol(1));
    check("basic_no_done_yet", 64'(ndone - bd), 64'd0);
    pulse_wcoln();
    check("basic_done_pulse", {62'd0, done, busy}, 64'h2);
    steps(3);
    check("basic_done_count", 64'(ndone - bd), 64'd1);
    check("basic_idle_busy", {63'd0, busy}, 64'd0);
    check("basic_no_overlap", 64'(nboth - bb), 64'd0);

    // Two channels: fresh weights for channel 1, no replay
    snap();
    start_job(5, 1, 2);
    steps(8);
    pulse_wcoln();
    check("ch2_wready", {63'd0, w_tready}, 64'd1);
    steps(8);
    check("ch2_loadw", 64'(nw - bw), 64'd10);
    check("ch2_first", wlog[bw+5], wcol(5));
    check("ch2_last", wlog[bw+9], wcol(9));
    check("ch2_loadip", 64'(nf - bf), 64'd2);
    pulse_wcoln();
    steps(2);
    check("ch2_done", 64'(ndone - bd), 64'd1);

    // Backpressure: weight tvalid toggles every other cycle
    snap();
    wtog = 1'b1;
    start_job(5, 1, 1);
    steps(16);
    wtog = 1'b0;
    check("bp_loadw", 64'(nw - bw), 64'd5);
    check("bp_xfers", 64'(nwx - bwx), 64'd5);
    for (int i = 0; i < 5; i++) begin
      check("bp_latency", 64'(wcyc[bw+i] - wxcyc[bwx+i]), 64'd1);
      check("bp_data", wlog[bw+i], wcol(i));
    end
    pulse_wcoln();
    steps(2);
    check("bp_done", 64'(ndone - bd), 64'd1);

    // KCOLS clamp and partial kernel width
    for (int t = 0; t < 3; t++) begin
      int kc, kexp;
      kc   = (t == 0) ? 0 : (t == 1) ? 9 : 3;
      kexp = (t == 2) ? 3 : 5;
      snap();
      start_job(kc, 2, 1);
      steps(8);
      pulse_wcoln();
      steps(8);
      check("kcols_loadw", 64'(nw - bw), 64'(2 * kexp));
      check("kcols_replay_last", wlog[bw+2*kexp-1], wcol(kexp - 1));
      pulse_wcoln();
      steps(2);
      check("kcols_done", 64'(ndone - bd), 64'd1);
    end

    // FCOLS=0 and NCHNL=0: done right after start, no stream activity
    snap();
    start_job(5, 0, 1);
    check("fcols0_done", {62'd0, done, busy}, 64'h2);
    step();
    check("fcols0_done_gone", {63'd0, done}, 64'd0);
    start_job(5, 1, 0);
    check("nchnl0_done", {63'd0, done}, 64'd1);
    steps(2);
    check("zero_cfg_no_rdy", 64'(nrdy - br), 64'd0);
    check("zero_cfg_no_strobe", 64'((nw - bw) + (nf - bf)), 64'd0);

    // Spurious start during WAIT_COL and wcoln during WFETCH
    snap();
    start_job(5, 2, 1);
    wcoln = 1'b1;
    steps(2);
    wcoln = 1'b0;
    steps(6);
    i_start = 1'b1;
    steps(3);
    i_start = 1'b0;
    pulse_wcoln();
    steps(8);
    pulse_wcoln();
    steps(2);
    check("spur_loadw", 64'(nw - bw), 64'd10);
    check("spur_loadip", 64'(nf - bf), 64'd2);
    check("spur_done", 64'(ndone - bd), 64'd1);

    // Reset in the middle of a replay, then a clean job
    start_job(5, 2, 1);
    steps(8);
    pulse_wcoln();
    steps(2);
    check("rst_mid_replay_pulse", {63'd0, loadw}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_async_outs", all_outs(), 64'd0);
    step();
    check("rst_next_cycle_outs", all_outs(), 64'd0);
    rst_n = 1'b1;
    snap();
    steps(3);
    check("rst_no_partial", 64'((nw - bw) + (nf - bf)), 64'd0);
    start_job(5, 2, 1);
    steps(8);
    pulse_wcoln();
    steps(8);
    pulse_wcoln();
    steps(2);
    check("rst_rerun_loadw", 64'(nw - bw), 64'd10);
    check("rst_rerun_first", wlog[bw], wcol(0));
    check("rst_rerun_replay", wlog[bw+7], wcol(2));
    check("rst_rerun_done", 64'(ndone - bd), 64'd1);
    check("never_overlap", 64'(nboth), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/deconv_col_feeder.md
Name: deconv_col_feeder

Overview:
Upstream stage of the deconvolution column core. Pulls weight columns and feature-map columns from two valid/ready input streams and buffers one channel's weight columns. It replays those weight columns for every feature column, driving the core's load strobes (weight col, feature col, loadw, loadip). It paces itself on the core's per-column finish pulse and walks feature columns within a channel, then channels within a job.

Parameters:
SIZE_OF_WEIGHT, 5, kernel height in pixels and max weight columns buffered
SIZE_OF_FEATURE, 2, feature column height in pixels
PIX_WIDTH, 8, bits per pixel
REG_WIDTH, 32, config register width
CNT_WIDTH, 16, width of column/channel counters

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  start-job pulse, sampled in IDLE only
i_param_cfg_feature  in  REG_WIDTH  [15:0] FCOLS feature cols per channel, [31:16] NCHNL channels
i_param_cfg_weight  in  REG_WIDTH  [15:0] KCOLS weight cols per channel
s_weight_tdata  in  PIX_WIDTH*SIZE_OF_WEIGHT  weight column
s_weight_tvalid  in  1  weight stream valid
s_weight_tready  out  1  weight stream ready
s_feature_tdata  in  PIX_WIDTH*SIZE_OF_FEATURE  feature column
s_feature_tvalid  in  1  feature stream valid
s_feature_tready  out  1  feature stream ready
i_en_prcs_new_wcoln  in  1  core pulse: current feature column fully processed
o_weight_col  out  PIX_WIDTH*SIZE_OF_WEIGHT  weight column to core
o_feature_map_col  out  PIX_WIDTH*SIZE_OF_FEATURE  feature column to core
o_enable_loadw  out  1  one-cycle pulse, o_weight_col valid
o_enable_loadip  out  1  one-cycle pulse, o_feature_map_col valid
o_busy  out  1  high from accepted start until DONE
o_done  out  1  one-cycle pulse at job end

Behaviour:
- Reset: state IDLE. All outputs 0, including data buses, readies, busy and done. Counters 0. Buffer contents don't-care. Reset mid-job aborts the job; no partial strobes afterwards.
- Config is latched on accepted i_start. KCOLS is clamped: 0 or >SIZE_OF_WEIGHT becomes SIZE_OF_WEIGHT. FCOLS==0 or NCHNL==0 gives o_done the cycle after start, with no stream transfers.
- States: IDLE, WFETCH, FFETCH, WAIT_COL, REPLAY, DONE.
- IDLE: on i_start go to WFETCH; o_busy=1 from the next cycle. i_start is ignored in all other states.
- WFETCH:
  - s_weight_tready=1.
  - Each transfer (valid&ready) writes buffer[k] and registers data onto o_weight_col; o_enable_loadw pulses the next cycle (latency 1).
  - k increments per transfer. After the KCOLS-th transfer go to FFETCH. Back-to-back transfers sustain one column per cycle.
- FFETCH: s_feature_tready=1. A transfer registers o_feature_map_col, pulses o_enable_loadip the next cycle, then goes to WAIT_COL.
- WAIT_COL: both readies 0. On i_en_prcs_new_wcoln:
  - f<FCOLS-1: f++, go to REPLAY.
  - else if c<NCHNL-1: c++, f=0, go to WFETCH (fresh weights for the new channel).
  - else go to DONE.
- REPLAY:
  - Reads buffer[0..KCOLS-1], one per cycle, onto o_weight_col with o_enable_loadw high each cycle (KCOLS consecutive pulses).
  - Ordering is identical to the fetch order. Then go to FFETCH.
- DONE: o_done=1 for one cycle, o_busy drops the same cycle, then IDLE.
- i_en_prcs_new_wcoln outside WAIT_COL is ignored, including a pulse coincident with a final strobe.
- o_weight_col and o_feature_map_col hold their last value between strobes.
- o_enable_loadw and o_enable_loadip are never high in the same cycle.
- Streams stalled (valid=0): the state holds indefinitely, with no strobes.
- Counters wrap is impossible (bounded by latched config). Buffer index is k mod SIZE_OF_WEIGHT only through the clamp.

Decomposition:
- Package deconv_pkg:
  - state enum;
  - cfg field offsets/widths (FCOLS_LSB=0, NCHNL_LSB=16, KCOLS_LSB=0, field width 16).
- Sub-module deconv_wbuf: SIZE_OF_WEIGHT x (PIX_WIDTH*SIZE_OF_WEIGHT) register file, 1 write port, 1 sync-free combinational read port, no reset on storage.

Test Plan:
- Basic job, KCOLS=5, FCOLS=2, NCHNL=1, streams always valid, weights 0x01..0x05 per column:
  - 5 loadw pulses on consecutive cycles, then 1 loadip.
  - After a wcoln pulse: 5 replay pulses with identical data order, then loadip for feature col 2.
  - After the final wcoln: o_done once.
- Two channels (NCHNL=2, FCOLS=1): after the first wcoln, s_weight_tready=1 again and fresh weights 0x11..0x15 appear on loadw. No replay occurs.
- Backpressure: weight tvalid toggles every other cycle. The loadw count stays exactly KCOLS, each pulse 1 cycle after its transfer, with no duplicate or skipped column.
- Config edges:
  - KCOLS=0 or 9 behaves as 5 columns.
  - FCOLS=0: o_done the cycle after i_start, zero tready cycles.
- Spurious inputs: i_start during WAIT_COL and wcoln during WFETCH are both ignored. Strobe counts are unchanged versus the baseline run.
- Reset mid-REPLAY (after the 2nd pulse): all outputs 0 next cycle. A new start runs a clean job from WFETCH.
